fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Pipelined instruction-fetch front end for the WISC core. Owns the PC, issues
//  requests to the synchronous instruction memory and buffers returned
//  instructions in a DEPTH-entry FIFO. Delivers them to the decode stage over a
//  valid/ready handshake, with the matching PC+2 for each instruction.
//  Branch/jump redirects from the execute/mem stages flush it. Halt opcodes stop it.
// PARAMETERS
//  DEPTH     4          queue entries; power of 2, >=2
//  RESET_PC  16'h0000   PC issued first after reset
//  HALT_OP   5'b00000   instr[15:11] value that stops fetch
// PORTS
//  clk          in   1   clock; all state on posedge
//  rst          in   1   asynchronous reset, active-low
//  redirect     in   1   taken branch/jump; flushes queue and in-flight fetch
//  redirect_pc  in   16  new fetch address, sampled when redirect=1
//  imem_req     out  1   fetch request this cycle
//  imem_addr    out  16  fetch address; valid when imem_req=1
//  imem_data    in   16  instruction; valid the cycle after imem_req
//  id_valid     out  1   id_instr/id_pc_plus2 valid
//  id_ready     in   1   decode accepts; transfer when id_valid & id_ready
//  id_instr     out  16  head-of-queue instruction
//  id_pc_plus2  out  16  address of id_instr + 2
//  halted       out  1   fetch permanently stopped
//  err          out  1   sticky error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0): pc=RESET_PC, queue empty, inflight=0, state=RUN. All outputs 0.
//  PC/issue: imem_req=1 iff state==RUN && !redirect && (count+inflight)<DEPTH.
//    imem_addr=pc. On issue: pc<=pc+2 (16-bit wrap, FFFE->0000), inflight<=1.
//  Response: if inflight && !redirect, push {imem_data, imem_addr_q+2} next cycle.
//    Latency is 2 cycles from request to id_valid; there is no bypass.
//  Credit rule: count+inflight never exceeds DEPTH. Overflow cannot occur.
//    Push and pop in the same cycle leave count unchanged, including when full.
//  Output: id_valid=(count!=0). Head stays stable while id_valid & !id_ready.
//    Pop on id_valid & id_ready.
//  Redirect (highest priority): the next cycle has count=0 and inflight=0.
//    The response arriving that cycle is discarded. pc<=redirect_pc with bit0 forced 0.
//    No request is issued in the redirect cycle; fetch resumes the cycle after.
//    A pop in the same cycle is ignored, because the queue is flushed.
//  FSM: RUN -> DRAIN when a pushed instr has [15:11]==HALT_OP.
//    DRAIN: issue stops, and younger responses already in flight are discarded.
//      The queue drains normally, halt instruction included.
//    DRAIN -> HALTED when the halt instr is popped. halted<=1 that cycle.
//    DRAIN + redirect -> RUN: the halt was wrong-path.
//    HALTED: terminal until reset. Redirect is ignored, id_valid=0, imem_req=0.
//  Reset mid-operation: async reset clears everything immediately, whatever the state.
// CONFIGURATION
//  FETCH_ERR_EN defined:
//    err<=1 on a redirect with redirect_pc[0]=1 (misaligned).
//    err<=1 on a pop attempted while empty (id_ready & !id_valid is legal and
//      does not count; only an internal pop with count==0 counts).
//    err is sticky until reset. The redirect is still taken with bit0 cleared.
//  FETCH_ERR_EN undefined: err tied 0; bit0 is cleared silently.
// TESTING
//  1 Reset release, id_ready=1, imem returns 16'hC000+addr:
//    req addr 0000,0002,0004.. on consecutive cycles.
//    id_valid first rises 2 cycles after the first req.
//    id_instr=C000, then C002, with id_pc_plus2=0002, 0004.
//  2 id_ready=0 for 10 cycles: exactly DEPTH=4 reqs (0000..0006), then imem_req=0.
//    Raise id_ready: entries pop in order, and requests resume at 0008.
//  3 Redirect to 0x0100 while queue holds 3 and one fetch is in flight:
//    next cycle id_valid=0. Next req addr=0100, and no stale instr is ever delivered.
//  4 Return 16'h0000 at addr 0004:
//    instrs 0000,0002,0004 are delivered, and no req beyond 0006 is issued.
//    halted=1 after 0004 is popped. A later redirect leaves halted=1, imem_req=0.
//  5 Halt fetched, then redirect to 0x0040 before it pops:
//    state returns to RUN, halted stays 0, req addr 0040.
//  6 FETCH_ERR_EN: redirect_pc=0x0031 -> err=1 and stays 1; next req addr=0030.
//    Assert rst=0 mid-stream: err, id_valid and imem_req drop immediately, and pc returns to RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch front end. Owns the PC, issues requests to a
//                synchronous instruction memory, buffers returned instructions
//                in a DEPTH-entry FIFO and hands them to decode over a
//                valid/ready handshake along with PC+2. Redirects flush the
//                queue and any in-flight fetch; a halt opcode stops fetch.
//                Optional macro FETCH_ERR_EN enables the sticky err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [4:0]  HALT_OP  = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [15:0] id_instr,
   output logic [15:0] id_pc_plus2,
   output logic        halted,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [15:0]     pc;
   logic [15:0]     addr_q;
   logic            inflight;
   logic [CW-1:0]   count;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [31:0]     mem [DEPTH];

   logic            live;
   logic            take_redirect;
   logic [CW-1:0]   occupancy;
   logic            issue;
   logic            push;
   logic            pop;
   logic            is_halt;
   logic [31:0]     head_entry;

   // Once halted, redirects are ignored; otherwise a redirect overrides everything.
   assign live          = (state != HALTED);
   assign take_redirect = redirect && live;

   // Credit: entries queued plus the one possibly in flight never exceed DEPTH.
   assign occupancy = count + CW'(inflight);
   assign issue     = rst && (state == RUN) && !redirect && (occupancy < CW'(DEPTH));

   // A response is only kept while still running; in DRAIN it is younger than the halt.
   assign push    = inflight && !redirect && (state == RUN);
   assign is_halt = (imem_data[15:11] == HALT_OP);

   assign id_valid   = live && (count != '0);
   assign pop        = id_valid && id_ready && !take_redirect;
   assign head_entry = mem[head];

   assign imem_req    = issue;
   assign imem_addr   = issue ? pc : 16'h0000;
   assign id_instr    = id_valid ? head_entry[31:16] : 16'h0000;
   assign id_pc_plus2 = id_valid ? head_entry[15:0]  : 16'h0000;
   assign halted      = (state == HALTED);

   // State register for the run/drain/halted controller.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nx;
   end

   // Next state: halt push enters DRAIN; last pop in DRAIN is the halt itself.
   always_comb begin
      state_nx = state;
      case (state)
         RUN: begin
            if (push && is_halt) state_nx = DRAIN;
         end
         DRAIN: begin
            if (redirect)                          state_nx = RUN;
            else if (pop && (count == CW'(1)))     state_nx = HALTED;
         end
         HALTED: begin
            state_nx = HALTED;
         end
         default: begin
            state_nx = RUN;
         end
      endcase
   end

   // PC, in-flight flag and address of the outstanding request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         addr_q   <= 16'h0000;
         inflight <= 1'b0;
      end else if (take_redirect) begin
         pc       <= redirect_pc & 16'hFFFE;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc     <= pc + 16'd2;
            addr_q <= pc;
         end
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (take_redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage holds {instruction, address+2}; data needs no reset.
   always_ff @(posedge clk) begin
      if (push && !take_redirect) mem[tail] <= {imem_data, addr_q + 16'd2};
   end

`ifdef FETCH_ERR_EN
   // Sticky error: misaligned redirect target, or an internal pop of an empty queue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if ((take_redirect && redirect_pc[0]) || (pop && (count == '0)))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire
